// File: rtl/godai_arb_pkg.sv
// Shared types and constants for the godai instruction/data memory arbiter.
package godai_arb_pkg;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/godai_arb_id_fifo.sv
// In-order FIFO of requester IDs; one entry per granted, not-yet-answered transaction.
module godai_arb_id_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/godai_mem_arbiter.sv
// Shares one memory bus between instruction fetch and data LSU, steering in-order responses back.
// Define GODAI_ARB_ROUND_ROBIN_EN to alternate winners on simultaneous requests.
module godai_mem_arbiter
  import godai_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  mem_req_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  protocol_err_o
);

  state_e     state_q;
  req_id_e    lock_id_q;
  req_id_e    winner;
  req_id_e    both_pick;
  logic       any_req, xfer;
  logic       fifo_full, fifo_empty, fifo_pop;
  logic [0:0] fifo_head;
  logic       head_valid_data, head_valid_instr;
  logic       protocol_err_q, protocol_err_d;

  assign any_req = instr_req_i || data_req_i;

`ifdef GODAI_ARB_ROUND_ROBIN_EN
  req_id_e last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_q <= REQ_INSTR;
    else if (xfer) last_q <= winner;
  end

  assign both_pick = (last_q == REQ_DATA) ? REQ_INSTR : REQ_DATA;
`else
  assign both_pick = REQ_DATA;
`endif

  always_comb begin
    winner = REQ_INSTR;
    if (state_q == LOCKED)              winner = lock_id_q;
    else if (data_req_i && instr_req_i) winner = both_pick;
    else if (data_req_i)                winner = REQ_DATA;
  end

  assign mem_req_o   = any_req && !fifo_full;
  assign xfer        = mem_req_o && mem_gnt_i;
  assign instr_gnt_o = xfer && (winner == REQ_INSTR);
  assign data_gnt_o  = xfer && (winner == REQ_DATA);

  // Attributes are zeroed with no requester so the bus idles quiet.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (any_req) begin
      if (winner == REQ_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = BE_FULL;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  // Lock is released only by an actual transfer, not a bare grant while blocked by full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= REQ_INSTR;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req_o && !mem_gnt_i) begin
            state_q   <= LOCKED;
            lock_id_q <= winner;
          end
        end
        LOCKED: begin
          if (xfer) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_pop = mem_rvalid_i && !fifo_empty;

  godai_arb_id_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (xfer),
    .pop_i   (fifo_pop),
    .data_i  (winner),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign head_valid_data  = !fifo_empty && (fifo_head == REQ_DATA);
  assign head_valid_instr = !fifo_empty && (fifo_head == REQ_INSTR);

  assign instr_rvalid_o = mem_rvalid_i && head_valid_instr;
  assign data_rvalid_o  = mem_rvalid_i && head_valid_data;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign data_err_o     = mem_err_i && head_valid_data;

  assign protocol_err_d = protocol_err_q || (mem_rvalid_i && fifo_empty);
  assign protocol_err_o = protocol_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) protocol_err_q <= 1'b0;
    else     protocol_err_q <= protocol_err_d;
  end

endmodule

// File: tb/tb_godai_mem_arbiter.sv
// Directed bench for godai_mem_arbiter: expected responses are queued at grant time, a monitor checks them.
module tb_godai_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req_i, instr_gnt_o, instr_rvalid_o;
  logic [AW-1:0] instr_addr_i;
  logic [DW-1:0] instr_rdata_o;
  logic          data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]    data_be_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i, data_rdata_o;
  logic          mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i, protocol_err_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] exp_i[$];
  logic [DW:0]   exp_d[$];

  always #5 clk = ~clk;

  godai_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (instr_req_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_addr_i   (instr_addr_i),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i),
    .protocol_err_o (protocol_err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
  endtask

  task automatic respond(input logic [DW-1:0] rdata, input logic err);
    tick();
    idle();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    mem_err_i    = err;
    smp();
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    logic [DW-1:0] ei;
    logic [DW:0]   ed;
    if (instr_rvalid_o) begin
      if (exp_i.size() == 0) begin
        tests++; fails++;
        $display("FAIL instr_rvalid_unexpected: got 1 expected 0 (rdata 0x%0h)", instr_rdata_o);
      end else begin
        ei = exp_i.pop_front();
        chk("instr_rdata", 64'(instr_rdata_o), 64'(ei));
        chk("data_err_on_fetch", 64'(data_err_o), 64'd0);
      end
    end
    if (data_rvalid_o) begin
      if (exp_d.size() == 0) begin
        tests++; fails++;
        $display("FAIL data_rvalid_unexpected: got 1 expected 0 (rdata 0x%0h)", data_rdata_o);
      end else begin
        ed = exp_d.pop_front();
        chk("data_rdata", 64'(data_rdata_o), 64'(ed[DW-1:0]));
        chk("data_err", 64'(data_err_o), 64'(ed[DW]));
      end
    end
    if (instr_rvalid_o && data_rvalid_o) begin
      tests++; fails++;
      $display("FAIL rvalid_both: got 1 expected 0");
    end
    if (!data_rvalid_o && data_err_o) begin
      tests++; fails++;
      $display("FAIL data_err_unqualified: got 1 expected 0");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    smp();
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_instr_gnt", 64'(instr_gnt_o), 64'd0);
    chk("rst_data_gnt", 64'(data_gnt_o), 64'd0);
    chk("rst_mem_be", 64'(mem_be_o), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err_o), 64'd0);
    tick();
    rst = 1'b0;

    // Single fetch, immediate grant, response two cycles later.
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h20; mem_gnt_i = 1'b1;
    smp();
    chk("t1_instr_gnt", 64'(instr_gnt_o), 64'd1);
    chk("t1_data_gnt", 64'(data_gnt_o), 64'd0);
    chk("t1_mem_req", 64'(mem_req_o), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr_o), 64'h20);
    chk("t1_mem_be", 64'(mem_be_o), 64'hF);
    chk("t1_mem_we", 64'(mem_we_o), 64'd0);
    exp_i.push_back(32'h0000_0013);
    tick();
    idle();
    smp();
    chk("t1_instr_gnt_drop", 64'(instr_gnt_o), 64'd0);
    respond(32'h0000_0013, 1'b0);

    // Simultaneous requests: data wins (also under round robin, since fetch was granted last).
    tick();
    idle();
    instr_req_i = 1'b1; instr_addr_i = 32'h24;
    data_req_i = 1'b1; data_addr_i = 32'h40; data_be_i = 4'hF; mem_gnt_i = 1'b1;
    smp();
    chk("t2_data_gnt", 64'(data_gnt_o), 64'd1);
    chk("t2_instr_gnt", 64'(instr_gnt_o), 64'd0);
    chk("t2_mem_addr_d", 64'(mem_addr_o), 64'h40);
    exp_d.push_back({1'b0, 32'hAAAA_0001});
    tick();
    data_req_i = 1'b0;
    smp();
    chk("t2_instr_gnt2", 64'(instr_gnt_o), 64'd1);
    chk("t2_mem_addr_i", 64'(mem_addr_o), 64'h24);
    exp_i.push_back(32'hBBBB_0002);
    respond(32'hAAAA_0001, 1'b0);
    respond(32'hBBBB_0002, 1'b0);

    // Stalled data store held stable for 4 cycles while fetch waits.
    for (int i = 0; i < 4; i++) begin
      tick();
      idle();
      data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
      data_addr_i = 32'h100; data_wdata_i = 32'hDEAD_BEEF;
      instr_req_i = 1'b1; instr_addr_i = 32'h30;
      mem_gnt_i = (i == 3);
      smp();
      chk("t3_mem_addr", 64'(mem_addr_o), 64'h100);
      chk("t3_mem_wdata", 64'(mem_wdata_o), 64'hDEAD_BEEF);
      chk("t3_mem_be", 64'(mem_be_o), 64'h3);
      chk("t3_mem_we", 64'(mem_we_o), 64'd1);
      chk("t3_instr_gnt", 64'(instr_gnt_o), 64'd0);
      chk("t3_data_gnt", 64'(data_gnt_o), (i == 3) ? 64'd1 : 64'd0);
    end
    exp_d.push_back({1'b0, 32'h0});
    tick();
    data_req_i = 1'b0; data_we_i = 1'b0;
    smp();
    chk("t3_instr_after", 64'(instr_gnt_o), 64'd1);
    exp_i.push_back(32'h0000_0055);
    respond(32'h0, 1'b0);
    respond(32'h0000_0055, 1'b0);

    // Locked fetch is not pre-empted by a later data request.
    tick();
    idle();
    instr_req_i = 1'b1; instr_addr_i = 32'h44;
    smp();
    chk("t4_mem_addr_i", 64'(mem_addr_o), 64'h44);
    tick();
    data_req_i = 1'b1; data_addr_i = 32'h48; data_be_i = 4'hF;
    smp();
    chk("t4_lock_addr", 64'(mem_addr_o), 64'h44);
    chk("t4_lock_be", 64'(mem_be_o), 64'hF);
    tick();
    mem_gnt_i = 1'b1;
    smp();
    chk("t4_lock_instr_gnt", 64'(instr_gnt_o), 64'd1);
    chk("t4_lock_data_gnt", 64'(data_gnt_o), 64'd0);
    exp_i.push_back(32'h0000_0066);
    tick();
    instr_req_i = 1'b0;
    smp();
    chk("t4_data_gnt", 64'(data_gnt_o), 64'd1);
    chk("t4_data_addr", 64'(mem_addr_o), 64'h48);
    exp_d.push_back({1'b0, 32'h0000_0077});
    respond(32'h0000_0066, 1'b0);
    respond(32'h0000_0077, 1'b0);

    // FIFO full: third request blocked until the cycle after the first response.
    for (int i = 0; i < 2; i++) begin
      tick();
      idle();
      instr_req_i = 1'b1; instr_addr_i = 32'h200 + 32'(4 * i); mem_gnt_i = 1'b1;
      smp();
      chk("t5_fill_gnt", 64'(instr_gnt_o), 64'd1);
      exp_i.push_back(32'h5000_0000 + 32'(i));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      instr_addr_i = 32'h208;
      smp();
      chk("t5_full_mem_req", 64'(mem_req_o), 64'd0);
      chk("t5_full_gnt", 64'(instr_gnt_o), 64'd0);
    end
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5000_0000;
    smp();
    chk("t5_pop_mem_req", 64'(mem_req_o), 64'd0);
    tick();
    mem_rvalid_i = 1'b0;
    smp();
    chk("t5_resume_mem_req", 64'(mem_req_o), 64'd1);
    chk("t5_resume_gnt", 64'(instr_gnt_o), 64'd1);
    exp_i.push_back(32'h5000_0002);
    respond(32'h5000_0001, 1'b0);
    respond(32'h5000_0002, 1'b0);

    // Error responses: reported for data, dropped for fetch.
    tick();
    idle();
    data_req_i = 1'b1; data_addr_i = 32'h80; data_be_i = 4'hF; mem_gnt_i = 1'b1;
    smp();
    chk("t6_data_gnt", 64'(data_gnt_o), 64'd1);
    exp_d.push_back({1'b1, 32'h0000_00E1});
    respond(32'h0000_00E1, 1'b1);
    tick();
    idle();
    instr_req_i = 1'b1; instr_addr_i = 32'h84; mem_gnt_i = 1'b1;
    smp();
    chk("t6_instr_gnt", 64'(instr_gnt_o), 64'd1);
    exp_i.push_back(32'h0000_00E2);
    respond(32'h0000_00E2, 1'b1);
    tick();
    idle();
    smp();
    chk("t6_no_protocol_err", 64'(protocol_err_o), 64'd0);

    // Reset with a fetch outstanding; the stray response must raise the sticky error.
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h90; mem_gnt_i = 1'b1;
    smp();
    chk("t7_gnt_before_rst", 64'(instr_gnt_o), 64'd1);
    tick();
    idle();
    rst = 1'b1;
    smp();
    chk("t7_rst_protocol_err", 64'(protocol_err_o), 64'd0);
    tick();
    rst = 1'b0;
    respond(32'h0BAD_0BAD, 1'b0);
    chk("t7_err_same_cycle", 64'(protocol_err_o), 64'd0);
    tick();
    idle();
    smp();
    chk("t7_protocol_err_set", 64'(protocol_err_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      smp();
    end
    chk("t7_protocol_err_sticky", 64'(protocol_err_o), 64'd1);

    chk("sb_instr_empty", 64'(exp_i.size()), 64'd0);
    chk("sb_data_empty", 64'(exp_d.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
